uart_word_assembler: RTL and testbench

Sits directly downstream of the UART receiver. It consumes the single-cycle byte strobe and byte bus, and packs WORD_BYTES consecutive bytes into one wide word, first byte least significant. The word is presented to the datapath, for example the modular-arithmetic / vote-processing stages, over a valid/ready handshake. An inter-byte timeout discards partial words so the host link resynchronises after a dropped byte.

---
 rtl/comm_pkg.sv | 18 +
 rtl/uart_word_assembler_timeout_counter.sv | 28 ++
 rtl/uart_word_assembler.sv | 92 +++++++++
 tb/tb_uart_word_assembler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared types and constants for the host serial link.
package comm_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        COLLECT_EMPTY,
        COLLECT_PARTIAL
    } collect_state_t;

    localparam int DEFAULT_WORD_BYTES = 4;
    localparam int INPUT_CLOCK_FREQ   = 100_000_000;

    function automatic int cycles_from_us(input int time_us);
        return time_us * (INPUT_CLOCK_FREQ / 1_000_000);
    endfunction

endpackage

// File: rtl/uart_word_assembler_timeout_counter.sv
// Inactivity timer. It reloads on clear, counts down while enabled, and
// pulses expired in the cycle it would pass its terminal count.
module timeout_counter #(
    parameter int CYCLES = 100_000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [TW-1:0] LOAD = TW'(CYCLES - 1);

    logic [TW-1:0] remaining;

    assign expired = enable && !clear && (remaining == '0);

    always_ff @(posedge clk_in) begin
        if (rst_in || clear || expired) begin
            remaining <= LOAD;
        end else if (enable) begin
            remaining <= remaining - TW'(1);
        end
    end

endmodule

// File: rtl/uart_word_assembler.sv
// Packs WORD_BYTES UART bytes (first byte in the low lane) into one word and
// hands it out over valid/ready, discarding partial words after inactivity.
//
// state           | meaning
// COLLECT_EMPTY   | no bytes of the next word held, timer parked
// COLLECT_PARTIAL | 1..WORD_BYTES-1 bytes held, timer running
module uart_word_assembler
    import comm_pkg::*;
#(
    parameter int WORD_BYTES     = DEFAULT_WORD_BYTES,
    parameter int TIMEOUT_CYCLES = cycles_from_us(1000)
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            new_byte_in,
    input  logic [7:0]                      byte_in,
    output logic [8*WORD_BYTES-1:0]         word_out,
    output logic                            word_valid_out,
    input  logic                            word_ready_in,
    output logic [$clog2(WORD_BYTES+1)-1:0] byte_count_out,
    output logic                            overflow_out,
    output logic                            timeout_out
);

    localparam int CW = $clog2(WORD_BYTES + 1);
    localparam logic [CW-1:0] LAST_LANE = CW'(WORD_BYTES - 1);

    logic [8*WORD_BYTES-1:0] collect;
    logic [8*WORD_BYTES-1:0] merged;
    collect_state_t          state;
    logic                    expired;
    logic                    slot_free;
    logic                    accept;

    assign state     = (byte_count_out == '0) ? COLLECT_EMPTY : COLLECT_PARTIAL;
    assign accept    = word_valid_out && word_ready_in;
    assign slot_free = !word_valid_out || word_ready_in;

    always_comb begin
        merged = collect;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (byte_count_out == CW'(k)) begin
                merged[8*k +: 8] = byte_in;
            end
        end
    end

    timeout_counter #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clear   (new_byte_in || (state == COLLECT_EMPTY)),
        .enable  (state == COLLECT_PARTIAL),
        .expired (expired)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            collect        <= '0;
            word_out       <= '0;
            word_valid_out <= 1'b0;
            byte_count_out <= '0;
            overflow_out   <= 1'b0;
            timeout_out    <= 1'b0;
        end else begin
            overflow_out <= 1'b0;
            timeout_out  <= 1'b0;
            if (accept) begin
                word_valid_out <= 1'b0;
            end
            if (new_byte_in) begin
                collect <= merged;
                if (byte_count_out == LAST_LANE) begin
                    byte_count_out <= '0;
                    if (slot_free) begin
                        word_out       <= merged;
                        word_valid_out <= 1'b1;
                    end else begin
                        overflow_out <= 1'b1;
                    end
                end else begin
                    byte_count_out <= byte_count_out + CW'(1);
                end
            end else if (expired) begin
                byte_count_out <= '0;
                timeout_out    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_word_assembler.sv
// Scoreboard bench for uart_word_assembler with WORD_BYTES=4, TIMEOUT_CYCLES=50.
module tb_uart_word_assembler;

    localparam int WB = 4;
    localparam int TMO = 50;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          new_byte_in = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic [8*WB-1:0] word_out;
    logic          word_valid_out;
    logic          word_ready_in = 1'b0;
    logic [2:0]    byte_count_out;
    logic          overflow_out;
    logic          timeout_out;

    int tests = 0;
    int errors = 0;
    int ovf_seen = 0;
    int tmo_seen = 0;
    logic [31:0] exp_q[$];

    uart_word_assembler #(
        .WORD_BYTES     (WB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .new_byte_in    (new_byte_in),
        .byte_in        (byte_in),
        .word_out       (word_out),
        .word_valid_out (word_valid_out),
        .word_ready_in  (word_ready_in),
        .byte_count_out (byte_count_out),
        .overflow_out   (overflow_out),
        .timeout_out    (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted word must match the head of the expected queue.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (overflow_out) ovf_seen++;
            if (timeout_out) tmo_seen++;
            if (word_valid_out && word_ready_in) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL sb_unexpected: got 0x%0h expected no word", word_out);
                end else begin
                    check("sb_word", 64'(word_out), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        new_byte_in = 1'b1;
        byte_in = b;
        tick();
        new_byte_in = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < WB; k++) begin
            send_byte(w[8*k +: 8]);
            if (k != WB - 1) tick(gap);
        end
    endtask

    initial begin
        tick(3);
        check("reset_word", 64'(word_out), 64'h0);
        check("reset_valid", 64'(word_valid_out), 64'h0);
        check("reset_count", 64'(byte_count_out), 64'h0);
        check("reset_ovf", 64'(overflow_out), 64'h0);
        check("reset_tmo", 64'(timeout_out), 64'h0);
        rst_in = 1'b0;
        tick(2);

        // Basic word, 10-cycle byte spacing, consumer always ready.
        word_ready_in = 1'b1;
        exp_q.push_back(32'h44332211);
        send_word(32'h44332211, 9);
        check("t1_valid", 64'(word_valid_out), 64'h1);
        check("t1_word", 64'(word_out), 64'h44332211);
        tick();
        check("t1_valid_drop", 64'(word_valid_out), 64'h0);
        check("t1_count", 64'(byte_count_out), 64'h0);

        // Back-pressure: second word dropped with a single overflow pulse.
        word_ready_in = 1'b0;
        exp_q.push_back(32'hA0A1A2A3);
        send_word(32'hA0A1A2A3, 2);
        tick(3);
        check("t2_hold_valid", 64'(word_valid_out), 64'h1);
        send_word(32'hB0B1B2B3, 0);
        check("t2_ovf_pulse", 64'(overflow_out), 64'h1);
        check("t2_word_kept", 64'(word_out), 64'hA0A1A2A3);
        tick();
        check("t2_ovf_once", 64'(overflow_out), 64'h0);
        check("t2_still_valid", 64'(word_valid_out), 64'h1);

        // Accept held word in the same cycle the next word completes.
        exp_q.push_back(32'hC0C1C2C3);
        send_byte(8'hC3);
        send_byte(8'hC2);
        send_byte(8'hC1);
        word_ready_in = 1'b1;
        send_byte(8'hC0);
        check("t3_valid", 64'(word_valid_out), 64'h1);
        check("t3_word", 64'(word_out), 64'hC0C1C2C3);
        check("t3_no_ovf", 64'(overflow_out), 64'h0);
        tick();
        check("t3_drained", 64'(word_valid_out), 64'h0);

        // Timeout after TMO idle cycles with a partial word pending.
        send_byte(8'hEE);
        send_byte(8'hEF);
        check("t4_count2", 64'(byte_count_out), 64'h2);
        tick(TMO - 1);
        check("t4_no_tmo_early", 64'(timeout_out), 64'h0);
        check("t4_count_held", 64'(byte_count_out), 64'h2);
        tick();
        check("t4_tmo_pulse", 64'(timeout_out), 64'h1);
        check("t4_count_zero", 64'(byte_count_out), 64'h0);
        tick();
        check("t4_tmo_once", 64'(timeout_out), 64'h0);
        exp_q.push_back(32'h04030201);
        send_word(32'h04030201, 0);
        check("t4_word", 64'(word_out), 64'h04030201);
        tick();

        // Byte lands exactly in the expiry cycle: byte wins.
        send_byte(8'h55);
        tick(TMO - 1);
        send_byte(8'h66);
        check("t5_no_tmo", 64'(timeout_out), 64'h0);
        check("t5_count2", 64'(byte_count_out), 64'h2);
        exp_q.push_back(32'h88776655);
        send_byte(8'h77);
        send_byte(8'h88);
        check("t5_word", 64'(word_out), 64'h88776655);
        tick();

        // Reset mid-word with a held output and a coincident strobe.
        word_ready_in = 1'b0;
        send_word(32'h99999999, 0);
        send_byte(8'hD1);
        send_byte(8'hD2);
        send_byte(8'hD3);
        rst_in = 1'b1;
        new_byte_in = 1'b1;
        byte_in = 8'hD4;
        tick();
        new_byte_in = 1'b0;
        rst_in = 1'b0;
        check("t6_word", 64'(word_out), 64'h0);
        check("t6_valid", 64'(word_valid_out), 64'h0);
        check("t6_count", 64'(byte_count_out), 64'h0);
        check("t6_ovf", 64'(overflow_out), 64'h0);
        word_ready_in = 1'b1;
        exp_q.push_back(32'h40302010);
        send_word(32'h40302010, 1);
        check("t6_clean_word", 64'(word_out), 64'h40302010);
        tick(3);

        check("sb_drained", 64'(exp_q.size()), 64'h0);
        check("ovf_total", 64'(ovf_seen), 64'd1);
        check("tmo_total", 64'(tmo_seen), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
